// File: rtl/regfile_pkg.sv
// Shared types and defaults for the pipelined-core register file.
//   rf_state_e : clear-sequencer states (CLEAR, RUN)
//   XLEN_DEF   : default data width
//   NREG_DEF   : default number of architectural registers
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer for the register file.
// Walks ptr from 0 to NREG-1, zeroing one entry per cycle, then enters RUN.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (restarts the sweep)
//   clr_we     : array write select, owns the write port while clearing
//   clr_addr   : entry being cleared
//   clr_data   : data written while clearing (always zero)
//   run        : file is in normal operation
//   ready      : registered "clear done" flag, identical to run
//
// state | meaning
// ------+----------------------------------------------------------
// CLEAR | zeroing RF[ptr] each cycle; reads, writes, issue blocked
// RUN   | normal operation; write port belongs to writeback
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            clr_we,
  output logic [AW-1:0]   clr_addr,
  output logic [XLEN-1:0] clr_data,
  output logic            run,
  output logic            ready
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        // Last entry is written on the same edge that moves to RUN,
        // giving exactly NREG cycles from release to ready.
        if (ptr_q == AW'(NREG - 1)) begin
          state_d = RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = ptr_q;
  assign clr_data = '0;
  assign run      = (state_q == RUN);
  assign ready    = run;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with pending-write scoreboard for the pipelined core.
// Two combinational read ports, one synchronous write port, a debug read
// port, and a hardware clear sweep after reset (rf_clear_seq).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   rs1/rs2, rv1/rv2    : read addresses / data (x0 reads as zero)
//   rd, indata, we      : write port; we also clears pending[rd]
//   issue_valid/issue_rd: destination issued this cycle, sets pending
//   busy1/busy2         : pending[rs1] / pending[rs2]
//   ready               : clear sweep finished
//   dbg_addr/dbg_data   : raw array read, never masked or bypassed
// Build option:
//   RF_BYPASS_EN : same-cycle write-to-read forwarding on rv1/rv2, with busy
//                  suppressed for the forwarded register.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] indata,
  input  logic            we,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            ready,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic [XLEN-1:0] clr_data;
  logic            run;

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [NREG-1:0] pending_q, pending_d;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  rf_clear_seq #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_data (clr_data),
    .run      (run),
    .ready    (ready)
  );

  // The sweep owns the write port while clearing; writeback is dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = clr_data;
    end else if (run && we && (rd != '0)) begin
      wr_en   = 1'b1;
      wr_addr = rd;
      wr_data = indata;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[wr_addr] = wr_data;
  end

  // No reset on the array: the clear sweep is the only initialiser.
  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  // Clear before set so a same-register issue and writeback leaves the bit
  // set: the newer producer is still in flight.
  always_comb begin
    pending_d = pending_q;
    if (run) begin
      if (we) pending_d[rd] = 1'b0;
      if (issue_valid && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin
    rv1   = '0;
    rv2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (run) begin
      if (rs1 != '0) rv1 = rf_q[rs1];
      if (rs2 != '0) rv2 = rf_q[rs2];
      busy1 = pending_q[rs1];
      busy2 = pending_q[rs2];
`ifdef RF_BYPASS_EN
      if (we && (rd != '0) && (rd == rs1)) begin
        rv1   = indata;
        busy1 = 1'b0;
      end
      if (we && (rd != '0) && (rd == rs2)) begin
        rv2   = indata;
        busy2 = 1'b0;
      end
`endif
    end
  end

  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1, rs2, rd, issue_rd, dbg_addr;
  logic [XLEN-1:0] rv1, rv2, indata, dbg_data;
  logic            we, issue_valid, busy1, busy2, ready;

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1         (rs1),
    .rs2         (rs2),
    .rv1         (rv1),
    .rv2         (rv2),
    .rd          (rd),
    .indata      (indata),
    .we          (we),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy1       (busy1),
    .busy2       (busy2),
    .ready       (ready),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Counts rising edges until ready goes high, bounded.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (ready !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic idle();
    we = 1'b0; issue_valid = 1'b0; rd = '0; issue_rd = '0; indata = '0;
  endtask

  int cyc;

  initial begin
    rst = 1'b1;
    rs1 = '0; rs2 = '0; dbg_addr = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_rv1", rv1, 32'd0);

    // First sweep, with writeback and issue to x9 held active throughout.
    @(negedge clk);
    rst = 1'b0;
    we = 1'b1; rd = 5'd9; indata = 32'hFF;
    issue_valid = 1'b1; issue_rd = 5'd9;
    rs1 = 5'd9;
    repeat (5) @(posedge clk);
    #1;
    chk("clear_rv1_forced0", rv1, 32'd0);
    chk("clear_busy1_forced0", {31'b0, busy1}, 32'd0);
    wait_ready(cyc);
    chk("clear_cycles_1", cyc + 5, 32'd32);
    @(negedge clk);
    idle();
    dbg_addr = 5'd9;
    #1;
    chk("clear_ignores_we", dbg_data, 32'd0);
    chk("clear_ignores_issue", {31'b0, busy1}, 32'd0);

    // Preload every entry with a pattern, then mark x3 pending.
    for (int i = 1; i < NREG; i++) begin
      @(negedge clk);
      we = 1'b1; rd = AW'(i); indata = 32'hA5A5A5A5;
    end
    @(negedge clk);
    idle();
    dbg_addr = 5'd17;
    #1;
    chk("preload_dbg17", dbg_data, 32'hA5A5A5A5);
    issue_valid = 1'b1; issue_rd = 5'd3;
    @(negedge clk);
    idle();
    rs1 = 5'd3;
    #1;
    chk("pending3_set", {31'b0, busy1}, 32'd1);

    // Reset in RUN: ready and pending must drop without a clock edge.
    rst = 1'b1;
    #1;
    chk("async_ready_drop", {31'b0, ready}, 32'd0);
    chk("async_busy_drop", {31'b0, busy1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(cyc);
    chk("clear_cycles_2", cyc, 32'd32);
    #1;
    chk("pending3_cleared", {31'b0, busy1}, 32'd0);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk($sformatf("swept_dbg%0d", i), dbg_data, 32'd0);
    end

    // Reset pulse ten cycles into a sweep restarts it from zero.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(cyc);
    chk("clear_cycles_restart", cyc, 32'd32);

    // Write x5, read in same cycle and the next.
    @(negedge clk);
    rs1 = 5'd5; rs2 = 5'd5;
    we = 1'b1; rd = 5'd5; indata = 32'hDEADBEEF;
    #1;
    chk("wr5_same_cycle", rv1, BYP ? 32'hDEADBEEF : 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("wr5_next_rv1", rv1, 32'hDEADBEEF);
    chk("wr5_next_rv2", rv2, 32'hDEADBEEF);

    // Writes to x0 are dropped.
    we = 1'b1; rd = 5'd0; indata = 32'h1234;
    @(negedge clk);
    idle();
    rs1 = 5'd0; dbg_addr = 5'd0;
    #1;
    chk("x0_rv1", rv1, 32'd0);
    chk("x0_dbg", dbg_data, 32'd0);

    // Scoreboard set/clear on x7.
    rs1 = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("issue7_no_bypass", {31'b0, busy1}, 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("issue7_busy", {31'b0, busy1}, 32'd1);
    we = 1'b1; rd = 5'd7; indata = 32'h77;
    #1;
    chk("wb7_same_busy", {31'b0, busy1}, BYP ? 32'd0 : 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("wb7_cleared", {31'b0, busy1}, 32'd0);
    chk("wb7_value", rv1, 32'h77);
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd7;
    we = 1'b1; rd = 5'd7; indata = 32'h78;
    @(negedge clk);
    idle();
    #1;
    chk("set_wins", {31'b0, busy1}, 32'd1);

    // Independent registers in one cycle: clear x7, set x8.
    rs2 = 5'd8;
    we = 1'b1; rd = 5'd7; indata = 32'h79;
    issue_valid = 1'b1; issue_rd = 5'd8;
    @(negedge clk);
    idle();
    #1;
    chk("indep_clear7", {31'b0, busy1}, 32'd0);
    chk("indep_set8", {31'b0, busy2}, 32'd1);

    // Pending x4 then writeback observed on read port 2.
    rs2 = 5'd4;
    issue_valid = 1'b1; issue_rd = 5'd4;
    @(negedge clk);
    idle();
    we = 1'b1; rd = 5'd4; indata = 32'h55;
    #1;
    chk("byp_rv2", rv2, BYP ? 32'h55 : 32'd0);
    chk("byp_busy2", {31'b0, busy2}, BYP ? 32'd0 : 32'd1);
    @(negedge clk);
    idle();
    dbg_addr = 5'd4;
    #1;
    chk("wb4_rv2", rv2, 32'h55);
    chk("wb4_busy2", {31'b0, busy2}, 32'd0);
    chk("wb4_dbg", dbg_data, 32'h55);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-cycle CPU integer register file, sized for the pipelined core. Provides 2 async read ports, 1 sync write port, and a hardware clear sequencer that zeroes every entry after reset. Adds a per-register pending-write scoreboard for hazard detection, plus a debug read port. Sits between decode (reads, issue) and writeback (write, clear pending).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers; power of 2, at least 4
AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rs1  in  AW  read port 1 address
rs2  in  AW  read port 2 address
rv1  out  XLEN  read port 1 data
rv2  out  XLEN  read port 2 data
rd  in  AW  write address
indata  in  XLEN  write data
we  in  1  write enable; also clears pending[rd]
issue_valid  in  1  instruction with destination issued this cycle
issue_rd  in  AW  destination register of issued instruction
busy1  out  1  pending[rs1]
busy2  out  1  pending[rs2]
ready  out  1  clear sequence done; file usable
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  RF[dbg_addr], raw

Behaviour:
- FSM states: CLEAR, RUN. rst asserted -> CLEAR, ptr=0, pending all 0, ready=0, asynchronously.
- CLEAR: each cycle RF[ptr]<=0, ptr<=ptr+1. When ptr==NREG-1, write entry and go to RUN. Exactly NREG cycles from rst deassert to ready=1. ready is registered (state==RUN).
- During CLEAR: we and issue_valid ignored; rv1/rv2/busy1/busy2 forced 0; dbg_data raw array.
- rst mid-CLEAR or mid-RUN: restart CLEAR from ptr=0. RF array itself has no reset; only the sequencer clears it.
- Read: rv1 = (rs1!=0) ? RF[rs1] : 0; same for rv2. Combinational, zero latency.
- Write (RUN): we && rd!=0 -> RF[rd]<=indata at edge, visible next cycle. Writes to x0 are discarded.
- Scoreboard (RUN): pending is an NREG-bit register, bit 0 is hardwired 0.
  - issue_valid && issue_rd!=0 sets pending[issue_rd].
  - we clears pending[rd].
  - Same register set and cleared in one cycle: set wins (newer producer in flight).
  - Different registers are handled independently in the same cycle.
  - busy1/busy2 are combinational from the registered pending bits. No bypass of the same-cycle issue.
- Write to a non-pending register is legal; no error is flagged.

Optional Feature:
RF_BYPASS_EN
- Defined: in RUN, if we && rd!=0 && rd==rs1, rv1=indata combinationally. Same rule for rv2. busy1/busy2 are forced 0 under the same match condition, because the value is available now. dbg_data is not bypassed.
- Undefined: reads return the old array value; the new value appears next cycle. busy is not affected by the same-cycle write.

Decomposition:
- Package regfile_pkg holds the state enum (CLEAR/RUN) and the default constants XLEN_DEF=32 and NREG_DEF=32.
- One sub-module, rf_clear_seq, contains the CLEAR/RUN FSM, ptr counter and ready output. It drives the write mux select, address and zero data into the array.
- Array, read muxes, scoreboard and bypass stay in regfile_sb.

Test Plan:
- Reset then release (NREG=32): ready=0 for exactly 32 cycles, then 1. All 32 dbg_data reads return 0x0, including after the array is preloaded with 0xA5A5A5A5 before reset.
- RUN, we=1 rd=5 indata=0xDEADBEEF: rs1=5 returns the old value in the same cycle (bypass off) and 0xDEADBEEF the next cycle. we=1 rd=0 indata=0x1234: rv1 with rs1=0 stays 0, and dbg_data[0] stays 0.
- issue_valid rd=7: next cycle busy1=1 with rs1=7. we rd=7: next cycle busy1=0. Issue rd=7 and we rd=7 in the same cycle with pending already set: pending[7] stays 1.
- Assert rst at CLEAR cycle 10 for 1 cycle: ready stays 0 for a full 32 cycles after the release. Assert rst in RUN with pending[3]=1: pending cleared and ready drops asynchronously.
- During CLEAR drive we=1 rd=9 indata=0xFF and issue rd=9: after ready, RF[9]=0 and busy=0.
- With RF_BYPASS_EN, pending[4]=1, we rd=4 indata=0x55 and rs2=4: rv2=0x55 and busy2=0 in the same cycle.
